regbank_file: RTL and testbench

//  Parametrised register file for the MIPS datapath. Integrates a write-address

---
 rtl/regbank_file.sv | 144 ++++++++++++++
 tb/tb_regbank_file.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/regbank_file.sv
// Parametrised MIPS register file: one-hot write decode, NREGS storage cells,
// two combinational read ports with optional same-cycle write forwarding.

module regbank_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (wen) q <= d;
  end
endmodule

module regbank_rport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]            raddr,
  input  logic                         wacc,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata
);
  // Compare against every implemented index so out-of-range addresses fall
  // through to zero instead of indexing past the array.
  always_comb begin
    rdata = '0;
    for (int j = 0; j < NREGS; j++) begin
      if (raddr == ADDR_W'(j) && !(ZERO_REG != 0 && j == 0))
        rdata = regs[j];
    end
    if (BYPASS != 0 && wacc && raddr == waddr)
      rdata = wdata;
  end
endmodule

module regbank_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [NREGS-1:0]  wr_onehot,
  output logic              wr_err
);
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  wr_req_t                      wr;
  logic [NREGS-1:0]             sel;
  logic [NREGS-1:0]             wen;
  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         in_range;
  logic                         zero_hit;
  logic                         accept;
  logic                         reject;
  logic [1:0][ADDR_W-1:0]       raddr;
  logic [1:0][DATA_W-1:0]       rdata;

  assign wr = '{we: we, addr: waddr, data: wdata};

  assign in_range = 32'(wr.addr) < 32'(NREGS);
  assign zero_hit = (ZERO_REG != 0) && (wr.addr == '0);
  assign accept   = wr.we && in_range && !zero_hit;
  assign reject   = wr.we && !accept;

  genvar i;
  generate
    for (i = 0; i < NREGS; i++) begin : g_reg
      assign sel[i] = wr.we && (wr.addr == ADDR_W'(i));
      assign wen[i] = sel[i] && accept;
      if (ZERO_REG != 0 && i == 0) begin : g_zero
        assign regs[i] = '0;
      end else begin : g_cell
        regbank_cell #(.DATA_W(DATA_W)) u_cell (
          .clk (clk),
          .rst (rst),
          .wen (wen[i]),
          .d   (wr.data),
          .q   (regs[i])
        );
      end
    end
  endgenerate

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  genvar p;
  generate
    for (p = 0; p < 2; p++) begin : g_rp
      regbank_rport #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
      ) u_rport (
        .regs  (regs),
        .raddr (raddr[p]),
        .wacc  (accept),
        .waddr (wr.addr),
        .wdata (wr.data),
        .rdata (rdata[p])
      );
    end
  endgenerate

  assign rdata_a = rdata[0];
  assign rdata_b = rdata[1];

  // Status reflects the write seen on the previous edge; idle cycles clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_onehot <= '0;
      wr_err    <= 1'b0;
    end else begin
      wr_onehot <= accept ? sel : '0;
      wr_err    <= reject;
    end
  end
endmodule

// File: tb/tb_regbank_file.sv
// Directed bench for regbank_file: default, no-bypass and 16-register builds
// share one stimulus stream.

module tb_regbank_file;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr_a = '0;
  logic [4:0]  raddr_b = '0;

  logic [31:0] d_ra, d_rb, nb_ra, nb_rb, s_ra, s_rb;
  logic [31:0] d_oh, nb_oh;
  logic [15:0] s_oh;
  logic        d_err, nb_err, s_err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  regbank_file u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(d_ra), .rdata_b(d_rb),
    .wr_onehot(d_oh), .wr_err(d_err));

  regbank_file #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(nb_ra), .rdata_b(nb_rb),
    .wr_onehot(nb_oh), .wr_err(nb_err));

  regbank_file #(.NREGS(16)) u_s16 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(s_ra), .rdata_b(s_rb),
    .wr_onehot(s_oh), .wr_err(s_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sweep_val(input int r);
    return (r == 0) ? 32'h0 : 32'(r) * 32'h0101_0101;
  endfunction

  initial begin
    logic [31:0] seen;
    logic [31:0] bit_i;
    seen = '0;

    // reset state
    #12;
    chk("rst_rdata", d_ra, 32'h0);
    chk("rst_onehot", d_oh, 32'h0);
    chk("rst_err", {31'h0, d_err}, 32'h0);
    rst = 1'b0;

    // 1: async reset between edges wipes a written register at once
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr_a = 5'd5;
    tick();
    we = 1'b0;
    #1;
    chk("t1_written", d_ra, 32'hDEAD_BEEF);
    chk("t1_onehot_pre", d_oh, 32'h0000_0020);
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_r5", d_ra, 32'h0);
    chk("t1_rst_onehot", d_oh, 32'h0);
    chk("t1_rst_err", {31'h0, d_err}, 32'h0);
    rst = 1'b0;

    // 2: write then read, onehot follows then clears
    we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; raddr_a = 5'd7;
    tick();
    we = 1'b0;
    #1;
    chk("t2_read", d_ra, 32'h1234_5678);
    chk("t2_onehot", d_oh, 32'h0000_0080);
    chk("t2_err", {31'h0, d_err}, 32'h0);
    tick();
    chk("t2_onehot_clr", d_oh, 32'h0);

    // 3: bypass vs. no bypass
    we = 1'b1; waddr = 5'd3; wdata = 32'h11;
    tick();
    wdata = 32'h22; raddr_a = 5'd3; raddr_b = 5'd3;
    #1;
    chk("t3_byp_a", d_ra, 32'h22);
    chk("t3_byp_b", d_rb, 32'h22);
    chk("t3_nobyp_a", nb_ra, 32'h11);
    chk("t3_nobyp_b", nb_rb, 32'h11);
    tick();
    we = 1'b0;
    #1;
    chk("t3_nobyp_after", nb_ra, 32'h22);

    // 4: writes to r0 are rejected and never forwarded
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr_a = 5'd0; raddr_b = 5'd0;
    #1;
    chk("t4_no_byp", d_ra, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("t4_r0", d_rb, 32'h0);
    chk("t4_err", {31'h0, d_err}, 32'h1);
    chk("t4_onehot", d_oh, 32'h0);
    tick();
    chk("t4_err_clr", {31'h0, d_err}, 32'h0);

    // 5: out-of-range write on the 16-register build
    we = 1'b1; waddr = 5'd20; wdata = 32'hAAAA_5555; raddr_a = 5'd20; raddr_b = 5'd7;
    #1;
    chk("t5_no_byp", s_ra, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("t5_err", {31'h0, s_err}, 32'h1);
    chk("t5_onehot", {16'h0, s_oh}, 32'h0);
    chk("t5_rd20", s_ra, 32'h0);
    chk("t5_r7_kept", s_rb, 32'h1234_5678);
    chk("t5_full_ok", d_ra, 32'hAAAA_5555);
    chk("t5_full_err", {31'h0, d_err}, 32'h0);
    raddr_b = 5'd3;
    #1;
    chk("t5_r3_kept", s_rb, 32'h22);

    // 6: sweep every register, each onehot bit seen exactly once
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = sweep_val(i);
      tick();
      we = 1'b0;
      #1;
      bit_i = 32'h1 << i;
      chk("t6_onehot", d_oh, bit_i);
      chk("t6_unique", seen & d_oh, 32'h0);
      seen = seen | d_oh;
    end
    chk("t6_all_seen", seen, 32'hFFFF_FFFE);
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i); raddr_b = 5'(31 - i);
      #1;
      chk("t6_rd_a", d_ra, sweep_val(i));
      chk("t6_rd_b", d_rb, sweep_val(31 - i));
      chk("t6_s16_a", s_ra, (i < 16) ? sweep_val(i) : 32'h0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
